// File: rtl/decode_queue_pkg.sv
// Shared decode definitions for decode_queue: MIPS32 opcode/funct encodings,
// the one-hot instruction class and the decoded-instruction record.
package decode_pkg;

  localparam int CLASS_W = 10;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU    = 10'b00_0000_0001,
    CLS_LOAD   = 10'b00_0000_0010,
    CLS_STORE  = 10'b00_0000_0100,
    CLS_BRANCH = 10'b00_0000_1000,
    CLS_JUMP   = 10'b00_0001_0000,
    CLS_MULDIV = 10'b00_0010_0000,
    CLS_CP0    = 10'b00_0100_0000,
    CLS_TLB    = 10'b00_1000_0000,
    CLS_CACHE  = 10'b01_0000_0000,
    CLS_TRAP   = 10'b10_0000_0000
  } instr_class_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;
  localparam logic [5:0] OP_CACHE   = 6'h2F;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  localparam logic [4:0] RS_MF      = 5'h00;
  localparam logic [4:0] RS_MT      = 5'h04;

  // COP0 function codes, valid only when instr[25] (CO) is set
  localparam logic [5:0] CO_TLBR    = 6'h01;
  localparam logic [5:0] CO_TLBWI   = 6'h02;
  localparam logic [5:0] CO_TLBWR   = 6'h06;
  localparam logic [5:0] CO_TLBP    = 6'h08;
  localparam logic [5:0] CO_ERET    = 6'h18;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef struct packed {
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [4:0]   shamt;
    logic [15:0]  imm16;
    logic [25:0]  imm26;
    logic         reg_we;
    logic [4:0]   wreg;
    instr_class_e cls;
    logic         ri;
  } decoded_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch/issue bundle of decode_queue. The master side (fetch/issue logic)
// drives pushes, flush and accept; the slave side (the queue) returns decoded lanes.
interface decode_queue_if #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
);
  import decode_pkg::*;

  localparam int ACC_W = $clog2(OUT_WIDTH + 1);

  logic                         flush;
  logic [IN_WIDTH-1:0]          in_valid;
  logic [32*IN_WIDTH-1:0]       in_instr;
  logic [32*IN_WIDTH-1:0]       in_pc;
  logic                         in_ready;
  logic [OUT_WIDTH-1:0]         out_valid;
  logic [32*OUT_WIDTH-1:0]      out_pc;
  logic [5*OUT_WIDTH-1:0]       out_rs;
  logic [5*OUT_WIDTH-1:0]       out_rt;
  logic [5*OUT_WIDTH-1:0]       out_rd;
  logic [5*OUT_WIDTH-1:0]       out_shamt;
  logic [16*OUT_WIDTH-1:0]      out_imm16;
  logic [26*OUT_WIDTH-1:0]      out_imm26;
  logic [OUT_WIDTH-1:0]         out_reg_we;
  logic [5*OUT_WIDTH-1:0]       out_wreg;
  logic [CLASS_W*OUT_WIDTH-1:0] out_class;
  logic [OUT_WIDTH-1:0]         out_ri;
  logic [ACC_W-1:0]             out_accept;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_accept,
    input  in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_shamt,
           out_imm16, out_imm26, out_reg_we, out_wreg, out_class, out_ri
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_accept,
    output in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_shamt,
           out_imm16, out_imm26, out_reg_we, out_wreg, out_class, out_ri
  );

endinterface

// File: rtl/decode_queue_lane.sv
// decode_lane: combinational single-word MIPS32 decoder.
// Optional macro DECODE_QUEUE_RI_EN flags unsupported words as reserved (class TRAP).
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [4:0]   rs_f;
  logic [4:0]   rt_f;
  logic [4:0]   rd_f;
  logic         writes;
  logic         supported;
  logic [4:0]   wreg;
  instr_class_e cls;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rs_f   = instr[25:21];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];

  always_comb begin
    writes    = 1'b0;
    supported = 1'b1;
    wreg      = rd_f;
    cls       = CLS_ALU;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: writes = 1'b1;
          FN_JR: cls = CLS_JUMP;
          FN_JALR: begin
            cls    = CLS_JUMP;
            writes = 1'b1;
          end
          FN_SYSCALL, FN_BREAK: cls = CLS_TRAP;
          FN_MFHI, FN_MFLO: begin
            cls    = CLS_MULDIV;
            writes = 1'b1;
          end
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = CLS_MULDIV;
          default: supported = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        case (rt_f)
          RT_BLTZ, RT_BGEZ: cls = CLS_BRANCH;
          RT_BLTZAL, RT_BGEZAL: begin
            cls    = CLS_BRANCH;
            writes = 1'b1;
            wreg   = REG_RA;
          end
          default: supported = 1'b0;
        endcase
      end
      OP_J: cls = CLS_JUMP;
      OP_JAL: begin
        cls    = CLS_JUMP;
        writes = 1'b1;
        wreg   = REG_RA;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        writes = 1'b1;
        wreg   = rt_f;
      end
      OP_COP0: begin
        // CO bit selects the eret/TLB function space over mfc0/mtc0
        if (instr[25]) begin
          case (funct)
            CO_ERET: cls = CLS_CP0;
            CO_TLBR, CO_TLBWI, CO_TLBWR, CO_TLBP: cls = CLS_TLB;
            default: supported = 1'b0;
          endcase
        end else begin
          case (rs_f)
            RS_MF: begin
              cls    = CLS_CP0;
              writes = 1'b1;
              wreg   = rt_f;
            end
            RS_MT: cls = CLS_CP0;
            default: supported = 1'b0;
          endcase
        end
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        cls    = CLS_LOAD;
        writes = 1'b1;
        wreg   = rt_f;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: cls = CLS_STORE;
      OP_CACHE: cls = CLS_CACHE;
      default: supported = 1'b0;
    endcase
    if (!supported) begin
      writes = 1'b0;
`ifdef DECODE_QUEUE_RI_EN
      cls    = CLS_TRAP;
`else
      cls    = CLS_ALU;
`endif
    end
  end

  always_comb begin
    dec.rs     = rs_f;
    dec.rt     = rt_f;
    dec.rd     = rd_f;
    dec.shamt  = instr[10:6];
    dec.imm16  = instr[15:0];
    dec.imm26  = instr[25:0];
    dec.wreg   = wreg;
    dec.reg_we = writes && (wreg != 5'd0);
    dec.cls    = cls;
`ifdef DECODE_QUEUE_RI_EN
    dec.ri     = !supported;
`else
    dec.ri     = 1'b0;
`endif
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: circular instruction buffer with OUT_WIDTH parallel decoders on its head.
// Optional macro DECODE_QUEUE_RI_EN enables reserved-instruction flagging in the lanes.
module decode_queue
  import decode_pkg::*;
#(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 8
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      pc_mem_d    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] pop_cnt;
  logic [CNT_W-1:0] accept_ext;
  logic             push_run;

  // in_ready looks only at the registered count, never at this cycle's pop
  assign bus.in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(IN_WIDTH);

  // Only the leading run of valid lanes is pushed, keeping program order gap-free
  always_comb begin
    push_cnt = '0;
    push_run = 1'b1;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (push_run && bus.in_valid[i]) begin
        push_cnt = push_cnt + CNT_W'(1);
      end else begin
        push_run = 1'b0;
      end
    end
    if (!bus.in_ready || bus.flush) begin
      push_cnt = '0;
    end
  end

  always_comb begin
    accept_ext = CNT_W'(bus.out_accept);
    pop_cnt    = (accept_ext < count_q) ? accept_ext : count_q;
  end

  always_comb begin
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_cnt);
      tail_d  = tail_q + PTR_W'(push_cnt);
      count_d = count_q + push_cnt - pop_cnt;
    end
  end

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (CNT_W'(i) < push_cnt) begin
        instr_mem_d[tail_q + PTR_W'(i)] = bus.in_instr[32*i +: 32];
        pc_mem_d[tail_q + PTR_W'(i)]    = bus.in_pc[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: stale entries are masked by out_valid
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_lane
    logic [PTR_W-1:0] rd_idx;
    decoded_t         dec;

    assign rd_idx = head_q + PTR_W'(g);

    decode_lane u_decode_lane (
      .instr (instr_mem_q[rd_idx]),
      .dec   (dec)
    );

    assign bus.out_valid[g]                    = count_q > CNT_W'(g);
    assign bus.out_pc[32*g +: 32]              = pc_mem_q[rd_idx];
    assign bus.out_rs[5*g +: 5]                = dec.rs;
    assign bus.out_rt[5*g +: 5]                = dec.rt;
    assign bus.out_rd[5*g +: 5]                = dec.rd;
    assign bus.out_shamt[5*g +: 5]             = dec.shamt;
    assign bus.out_imm16[16*g +: 16]           = dec.imm16;
    assign bus.out_imm26[26*g +: 26]           = dec.imm26;
    assign bus.out_reg_we[g]                   = dec.reg_we;
    assign bus.out_wreg[5*g +: 5]              = dec.wreg;
    assign bus.out_class[CLASS_W*g +: CLASS_W] = dec.cls;
    assign bus.out_ri[g]                       = dec.ri;
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: table-driven decode vectors plus
// hand-written fill/wrap/flush/underflow sequences checked against a scoreboard queue.
module tb_decode_queue;

  localparam int IW    = 2;
  localparam int OW    = 2;
  localparam int DEPTH = 8;

  localparam logic [9:0] C_ALU    = 10'h001;
  localparam logic [9:0] C_LOAD   = 10'h002;
  localparam logic [9:0] C_STORE  = 10'h004;
  localparam logic [9:0] C_BRANCH = 10'h008;
  localparam logic [9:0] C_JUMP   = 10'h010;
  localparam logic [9:0] C_MULDIV = 10'h020;
  localparam logic [9:0] C_CP0    = 10'h040;
  localparam logic [9:0] C_TLB    = 10'h080;
  localparam logic [9:0] C_CACHE  = 10'h100;
  localparam logic [9:0] C_TRAP   = 10'h200;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wreg;
    logic [9:0]  cls;
    logic        ri;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wreg;
    logic [9:0]  cls;
    logic        ri;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tbl[23];
  exp_t idle_e;

  decode_queue_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dq_if ();

  decode_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dq_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkRow(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.instr = v.instr; e.we = v.we; e.wreg = v.wreg; e.cls = v.cls; e.ri = v.ri;
    return e;
  endfunction

  // addiu rt, zero, pc[15:0]: writes rt unless rt is $0
  function automatic exp_t mkAlu(input logic [31:0] pc, input logic [4:0] rt);
    exp_t e;
    e.pc = pc; e.instr = {6'h09, 5'd0, rt, pc[15:0]};
    e.we = (rt != 5'd0); e.wreg = rt; e.cls = C_ALU; e.ri = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string tag);
    int sz = sb.size();
    cmp({tag, ".in_ready"}, 64'(dq_if.in_ready), 64'((DEPTH - sz) >= IW));
    for (int i = 0; i < OW; i++) begin
      cmp($sformatf("%s.valid%0d", tag, i), 64'(dq_if.out_valid[i]), 64'(sz > i));
      if (sz > i) begin
        exp_t e = sb[i];
        cmp($sformatf("%s.pc%0d", tag, i), 64'(dq_if.out_pc[32*i +: 32]), 64'(e.pc));
        cmp($sformatf("%s.reg_we%0d", tag, i), 64'(dq_if.out_reg_we[i]), 64'(e.we));
        cmp($sformatf("%s.wreg%0d", tag, i), 64'(dq_if.out_wreg[5*i +: 5]), 64'(e.wreg));
        cmp($sformatf("%s.class%0d", tag, i), 64'(dq_if.out_class[10*i +: 10]), 64'(e.cls));
        cmp($sformatf("%s.ri%0d", tag, i), 64'(dq_if.out_ri[i]), 64'(e.ri));
        cmp($sformatf("%s.fields%0d", tag, i),
            64'({dq_if.out_rs[5*i +: 5], dq_if.out_rt[5*i +: 5], dq_if.out_rd[5*i +: 5],
                 dq_if.out_shamt[5*i +: 5], dq_if.out_imm16[16*i +: 16], dq_if.out_imm26[26*i +: 26]}),
            64'({e.instr[25:21], e.instr[20:16], e.instr[15:11], e.instr[10:6],
                 e.instr[15:0], e.instr[25:0]}));
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input exp_t e0, input exp_t e1,
                               input int acc, input logic fl, input string tag);
    int sz  = sb.size();
    bit rdy = (DEPTH - sz) >= IW;
    int n   = (acc < sz) ? acc : sz;
    int k   = v[0] ? (v[1] ? 2 : 1) : 0;
    dq_if.flush      = fl;
    dq_if.in_valid   = v;
    dq_if.in_instr   = {e1.instr, e0.instr};
    dq_if.in_pc      = {e1.pc, e0.pc};
    dq_if.out_accept = 2'(acc);
    @(posedge clk);
    #1;
    dq_if.flush      = 1'b0;
    dq_if.in_valid   = '0;
    dq_if.out_accept = '0;
    if (fl) begin
      sb.delete();
    end else begin
      for (int j = 0; j < n; j++) void'(sb.pop_front());
      if (rdy && k >= 1) sb.push_back(e0);
      if (rdy && k >= 2) sb.push_back(e1);
    end
    checkOutput(tag);
  endtask

  task automatic doReset(input string tag);
    reset            = 1'b1;
    dq_if.flush      = 1'b0;
    dq_if.in_valid   = '0;
    dq_if.in_instr   = '0;
    dq_if.in_pc      = '0;
    dq_if.out_accept = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] pc;
    idle_e = '{pc: 32'h0, instr: 32'h0, we: 1'b0, wreg: 5'd0, cls: 10'h0, ri: 1'b0};

    tbl[0]  = '{32'h24080005, 1'b1, 5'd8,  C_ALU,    1'b0};
    tbl[1]  = '{32'h0C000040, 1'b1, 5'd31, C_JUMP,   1'b0};
    tbl[2]  = '{32'h04100003, 1'b1, 5'd31, C_BRANCH, 1'b0};
    tbl[3]  = '{32'h012A0021, 1'b0, 5'd0,  C_ALU,    1'b0};
    tbl[4]  = '{32'h00000000, 1'b0, 5'd0,  C_ALU,    1'b0};
    tbl[5]  = '{32'h8FA90004, 1'b1, 5'd9,  C_LOAD,   1'b0};
    tbl[6]  = '{32'hAFA90004, 1'b0, 5'd0,  C_STORE,  1'b0};
    tbl[7]  = '{32'h11090003, 1'b0, 5'd0,  C_BRANCH, 1'b0};
    tbl[8]  = '{32'h03E00008, 1'b0, 5'd0,  C_JUMP,   1'b0};
    tbl[9]  = '{32'h0120F809, 1'b1, 5'd31, C_JUMP,   1'b0};
    tbl[10] = '{32'h01090018, 1'b0, 5'd0,  C_MULDIV, 1'b0};
    tbl[11] = '{32'h00005012, 1'b1, 5'd10, C_MULDIV, 1'b0};
    tbl[12] = '{32'h40086000, 1'b1, 5'd8,  C_CP0,    1'b0};
    tbl[13] = '{32'h40886000, 1'b0, 5'd12, C_CP0,    1'b0};
    tbl[14] = '{32'h42000018, 1'b0, 5'd0,  C_CP0,    1'b0};
    tbl[15] = '{32'h42000002, 1'b0, 5'd0,  C_TLB,    1'b0};
    tbl[16] = '{32'hBC000000, 1'b0, 5'd0,  C_CACHE,  1'b0};
    tbl[17] = '{32'h0000000C, 1'b0, 5'd0,  C_TRAP,   1'b0};
    tbl[18] = '{32'h3C081234, 1'b1, 5'd8,  C_ALU,    1'b0};
    tbl[19] = '{32'h00094080, 1'b1, 5'd8,  C_ALU,    1'b0};
`ifdef DECODE_QUEUE_RI_EN
    tbl[20] = '{32'hFC000000, 1'b0, 5'd0,  C_TRAP,   1'b1};
`else
    tbl[20] = '{32'hFC000000, 1'b0, 5'd0,  C_ALU,    1'b0};
`endif
    tbl[21] = '{32'h98050000, 1'b1, 5'd5,  C_LOAD,   1'b0};
    tbl[22] = '{32'h04110001, 1'b1, 5'd31, C_BRANCH, 1'b0};

    doReset("reset");

    // One decode vector per cycle; each is checked on lane 0 then accepted
    for (int i = 0; i < 23; i++) begin
      applyStimulus(2'b01, mkRow(tbl[i], 32'h100 + 32'(4*i)), idle_e, (i == 0) ? 0 : 1, 1'b0,
                    $sformatf("vec%0d", i));
    end
    applyStimulus(2'b00, idle_e, idle_e, 1, 1'b0, "vec_drain");

    applyStimulus(2'b11, mkRow(tbl[1], 32'h200), mkRow(tbl[2], 32'h204), 0, 1'b0, "pair_push");
    applyStimulus(2'b00, idle_e, idle_e, 2, 1'b0, "pair_pop");

    // Fill to full with no issue, then a dropped push, then partial drain
    pc = 32'h1000;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, mkAlu(pc, pc[6:2]), mkAlu(pc + 4, pc[6:2] + 5'd1), 0, 1'b0,
                    $sformatf("fill%0d", c));
      pc += 8;
    end
    applyStimulus(2'b11, mkAlu(32'hDEAD0000, 5'd3), mkAlu(32'hDEAD0004, 5'd4), 0, 1'b0, "full_drop");
    applyStimulus(2'b00, idle_e, idle_e, 2, 1'b0, "full_pop");

    for (int c = 0; c < 20; c++) begin
      applyStimulus(2'($urandom_range(0, 3)), mkAlu(pc, pc[6:2]), mkAlu(pc + 4, pc[6:2] + 5'd1),
                    int'($urandom_range(0, 2)), 1'b0, $sformatf("wrap%0d", c));
      pc += 8;
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(2'b00, idle_e, idle_e, 2, 1'b0, $sformatf("wrap_drain%0d", c));
    end

    // Flush with a simultaneous push at count=5
    applyStimulus(2'b11, mkAlu(32'h3000, 5'd1), mkAlu(32'h3004, 5'd2), 0, 1'b0, "fl_fill0");
    applyStimulus(2'b11, mkAlu(32'h3008, 5'd3), mkAlu(32'h300C, 5'd4), 0, 1'b0, "fl_fill1");
    applyStimulus(2'b01, mkAlu(32'h3010, 5'd5), idle_e, 0, 1'b0, "fl_fill2");
    applyStimulus(2'b11, mkAlu(32'h3014, 5'd6), mkAlu(32'h3018, 5'd7), 0, 1'b1, "flush");
    applyStimulus(2'b00, idle_e, idle_e, 0, 1'b0, "post_flush");

    // Over-accept at count=1 and an in_valid=10 pattern that pushes nothing
    applyStimulus(2'b01, mkAlu(32'h4000, 5'd9), idle_e, 0, 1'b0, "uf_push");
    applyStimulus(2'b10, mkAlu(32'h4004, 5'd10), mkAlu(32'h4008, 5'd11), 2, 1'b0, "uf_pop");
    applyStimulus(2'b01, mkAlu(32'h400C, 5'd12), idle_e, 0, 1'b0, "uf_repush");
    applyStimulus(2'b11, mkAlu(32'h4010, 5'd13), mkAlu(32'h4014, 5'd0), 1, 1'b0, "uf_more");

    doReset("reset_mid");
    applyStimulus(2'b01, mkAlu(32'h5000, 5'd14), idle_e, 0, 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
